// File: rtl/funct_generator_dds_pkg.sv
// Shared types and helpers for the DDS function generator.
package funct_generator_dds_pkg;

  typedef enum logic [1:0] {
    SIN   = 2'd0,
    COS   = 2'd1,
    TRIAN = 2'd2,
    SQUA  = 2'd3
  } wave_sel_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONFIG = 2'd1,
    RUN    = 2'd2,
    STALL  = 2'd3
  } fsm_state_e;

  // Number of fractional bits of the Q(int_bits).(data_width-int_bits) format.
  function automatic int fxp_frac_bits(input int data_width, input int int_bits);
    return data_width - int_bits;
  endfunction

endpackage

// File: rtl/funct_generator_lut.sv
// Single-waveform ROM with synchronous, enable-gated read. The table is built
// at elaboration from closed-form generators: Bhaskara sine (exact at the
// quarter points), linear triangle and +/-1.0 square, all in Q format.
module funct_generator_lut
  import funct_generator_dds_pkg::*;
#(
  parameter int        DATA_WIDTH = 32,
  parameter int        INT_BITS   = 4,
  parameter int        LUT_ADDR   = 8,
  parameter wave_sel_e WAVE       = SIN
) (
  input  logic                         clk,
  input  logic                         en,
  input  logic [LUT_ADDR-1:0]          addr,
  output logic signed [DATA_WIDTH-1:0] data
);

  localparam int N    = 1 << LUT_ADDR;
  localparam int FRAC = fxp_frac_bits(DATA_WIDTH, INT_BITS);

  function automatic logic [DATA_WIDTH-1:0] entry(input int idx);
    longint one, n, h, q, a, j, k, v;
    one = longint'(1) << FRAC;
    n   = longint'(N);
    h   = n / 2;
    q   = n / 4;
    if (WAVE == SQUA) begin
      v = (idx < h) ? one : -one;
    end else if (WAVE == TRIAN) begin
      if (idx < q)          k = idx;
      else if (idx < 3 * q) k = h - idx;
      else                  k = idx - n;
      v = (k * one) / q;
    end else begin
      j = (WAVE == COS) ? (idx + q) % n : longint'(idx);
      a = j % h;
      v = (one * 16 * a * (h - a)) / (5 * h * h - 4 * a * (h - a));
      if (j >= h) v = -v;
    end
    return DATA_WIDTH'(v);
  endfunction

  logic [DATA_WIDTH-1:0] rom [N];

  for (genvar i = 0; i < N; i++) begin : g_rom
    localparam logic [DATA_WIDTH-1:0] ENTRY = entry(i);
    assign rom[i] = ENTRY;
  end

  // Registered read, held while the pipeline is stalled.
  always_ff @(posedge clk) begin
    if (en) data <= rom[addr];
  end

endmodule

// File: rtl/funct_generator_phase_acc.sv
// Phase accumulator: loadable register with modular increment; exports the
// top LUT_ADDR bits as the waveform table address.
module funct_generator_phase_acc #(
  parameter int PHASE_WIDTH = 16,
  parameter int LUT_ADDR    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [PHASE_WIDTH-1:0] load_val,
  input  logic                   step_en,
  input  logic [PHASE_WIDTH-1:0] step,
  output logic [LUT_ADDR-1:0]    addr
);

  logic [PHASE_WIDTH-1:0] phase;

  // Load wins over stepping; the add wraps naturally modulo 2**PHASE_WIDTH.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          phase <= '0;
    else if (load)    phase <= load_val;
    else if (step_en) phase <= phase + step;
  end

  assign addr = phase[PHASE_WIDTH-1 -: LUT_ADDR];

endmodule

// File: rtl/funct_generator_dds.sv
// DDS function generator: phase accumulator -> waveform LUTs -> amplitude
// scale and DC offset, streamed out over valid/ready.
// Optional: define FUNCT_GEN_SAT_EN to saturate the offset add instead of wrapping.
module funct_generator_dds
  import funct_generator_dds_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    INT_BITS    = 4,
  parameter int                    LUT_ADDR    = 8,
  parameter int                    PHASE_WIDTH = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_AMP   = 32'h10000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en_i,
  input  logic                          conf_i,
  input  logic signed [INT_BITS-1:0]    amp_i,
  input  logic signed [DATA_WIDTH-1:0]  offset_i,
  input  logic [PHASE_WIDTH-1:0]        freq_i,
  input  logic [PHASE_WIDTH-1:0]        phase_i,
  input  logic [1:0]                    sel_i,
  input  logic                          ready_i,
  output logic                          valid_o,
  output logic signed [DATA_WIDTH-1:0]  data_o,
  output logic                          busy_o
);

  localparam int FRAC = fxp_frac_bits(DATA_WIDTH, INT_BITS);
  localparam logic [INT_BITS-1:0]   AMP_MIN_CODE = {1'b1, {(INT_BITS-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  fsm_state_e                    state;
  logic [PHASE_WIDTH-1:0]        freq_reg;
  logic signed [DATA_WIDTH-1:0]  offset_reg;
  logic signed [DATA_WIDTH-1:0]  amp_reg;
  wave_sel_e                     sel_reg;

  logic                          run_go;
  logic                          advance;
  logic [LUT_ADDR-1:0]           lut_addr;
  logic [LUT_ADDR-1:0]           addr_p1;
  logic                          vld_p1, vld_p2;
  logic signed [DATA_WIDTH-1:0]  sin_p2, cos_p2, tri_p2, squ_p2, wave_p2;

  // Whole pipeline moves together unless a valid sample is being refused.
  assign advance = !valid_o || ready_i;
  assign run_go  = en_i && ((state == RUN) || (state == STALL));

  // Keep the middle Q-format window of the full-width product.
  function automatic logic signed [DATA_WIDTH-1:0] scale(
    input logic signed [DATA_WIDTH-1:0] s,
    input logic signed [DATA_WIDTH-1:0] g
  );
    logic signed [2*DATA_WIDTH-1:0] p;
    p = s * g;
    return p[2*DATA_WIDTH-INT_BITS-1 -: DATA_WIDTH];
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] add_offset(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
`ifdef FUNCT_GEN_SAT_EN
    logic signed [DATA_WIDTH:0] sum;
    sum = {a[DATA_WIDTH-1], a} + {b[DATA_WIDTH-1], b};
    if (sum[DATA_WIDTH] != sum[DATA_WIDTH-1])
      return sum[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    return sum[DATA_WIDTH-1:0];
`else
    return a + b;
`endif
  endfunction

  // Control FSM plus configuration registers (loaded only in CONFIG).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy_o     <= 1'b0;
      freq_reg   <= '0;
      offset_reg <= '0;
      sel_reg    <= SIN;
      amp_reg    <= RESET_AMP;
    end else begin
      case (state)
        IDLE: begin
          if (conf_i) begin
            state <= CONFIG;
          end else if (en_i) begin
            state  <= RUN;
            busy_o <= 1'b1;
          end
        end
        CONFIG: begin
          freq_reg   <= freq_i;
          offset_reg <= offset_i;
          sel_reg    <= wave_sel_e'(sel_i);
          // Zero and the most negative code are not usable gains.
          if ((amp_i != '0) && (amp_i != AMP_MIN_CODE))
            amp_reg <= {amp_i, {FRAC{1'b0}}};
          state <= IDLE;
        end
        RUN: begin
          if (!en_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (valid_o && !ready_i) begin
            state <= STALL;
          end
        end
        default: begin
          if (!en_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (ready_i) begin
            state <= RUN;
          end
        end
      endcase
    end
  end

  funct_generator_phase_acc #(
    .PHASE_WIDTH (PHASE_WIDTH),
    .LUT_ADDR    (LUT_ADDR)
  ) u_phase_acc (
    .clk      (clk),
    .rst      (rst),
    .load     (state == CONFIG),
    .load_val (phase_i),
    .step_en  (run_go && advance),
    .step     (freq_reg),
    .addr     (lut_addr)
  );

  // ---- S1: capture table address from the accumulator ----
  always_ff @(posedge clk) begin
    if (run_go && advance) addr_p1 <= lut_addr;
  end

  // ---- S2: synchronous LUT reads, waveform select ----
  funct_generator_lut #(.DATA_WIDTH(DATA_WIDTH), .INT_BITS(INT_BITS), .LUT_ADDR(LUT_ADDR), .WAVE(SIN))
    u_lut_sin (.clk(clk), .en(advance), .addr(addr_p1), .data(sin_p2));
  funct_generator_lut #(.DATA_WIDTH(DATA_WIDTH), .INT_BITS(INT_BITS), .LUT_ADDR(LUT_ADDR), .WAVE(COS))
    u_lut_cos (.clk(clk), .en(advance), .addr(addr_p1), .data(cos_p2));
  funct_generator_lut #(.DATA_WIDTH(DATA_WIDTH), .INT_BITS(INT_BITS), .LUT_ADDR(LUT_ADDR), .WAVE(TRIAN))
    u_lut_tri (.clk(clk), .en(advance), .addr(addr_p1), .data(tri_p2));
  funct_generator_lut #(.DATA_WIDTH(DATA_WIDTH), .INT_BITS(INT_BITS), .LUT_ADDR(LUT_ADDR), .WAVE(SQUA))
    u_lut_squ (.clk(clk), .en(advance), .addr(addr_p1), .data(squ_p2));

  // Waveform mux; sel_reg only changes while idle so it never tears a stream.
  always_comb begin
    wave_p2 = sin_p2;
    case (sel_reg)
      COS:     wave_p2 = cos_p2;
      TRIAN:   wave_p2 = tri_p2;
      SQUA:    wave_p2 = squ_p2;
      default: wave_p2 = sin_p2;
    endcase
  end

  // Stage valids: cleared whenever the generator is not running (flush on exit).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (!run_go) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else if (advance) begin
      vld_p1 <= 1'b1;
      vld_p2 <= vld_p1;
    end
  end

  // ---- S3: amplitude scale, DC offset, output register ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      data_o  <= '0;
    end else if (!run_go) begin
      valid_o <= 1'b0;
    end else if (advance) begin
      valid_o <= vld_p2;
      if (vld_p2) data_o <= add_offset(scale(wave_p2, amp_reg), offset_reg);
    end
  end

endmodule

// File: tb/tb_funct_generator_dds.sv
// Directed bench for funct_generator_dds (default parameters, Q4.28).
module tb_funct_generator_dds;

  logic        clk = 1'b0;
  logic        rst;
  logic        en_i;
  logic        conf_i;
  logic [3:0]  amp_i;
  logic [31:0] offset_i;
  logic [15:0] freq_i;
  logic [15:0] phase_i;
  logic [1:0]  sel_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] data_o;
  logic        busy_o;

  int total = 0;
  int bad   = 0;
  int k;
  int rdy_cnt;
  bit ok;

  logic [31:0] ff00_exp [6];
  logic [31:0] pos_ovf_exp;
  logic [31:0] neg_ovf_exp;

  funct_generator_dds dut (
    .clk      (clk),
    .rst      (rst),
    .en_i     (en_i),
    .conf_i   (conf_i),
    .amp_i    (amp_i),
    .offset_i (offset_i),
    .freq_i   (freq_i),
    .phase_i  (phase_i),
    .sel_i    (sel_i),
    .ready_i  (ready_i),
    .valid_o  (valid_o),
    .data_o   (data_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cfg(input logic [3:0] a, input logic [31:0] off, input logic [15:0] f,
                     input logic [15:0] ph, input logic [1:0] s);
    @(negedge clk);
    amp_i = a; offset_i = off; freq_i = f; phase_i = ph; sel_i = s;
    conf_i = 1'b1;
    @(negedge clk);
    conf_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag, output bit got_it);
    got_it = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (valid_o) begin
        got_it = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got_it) chk({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic run_one(input string tag, input logic [31:0] exp);
    bit v;
    en_i = 1'b1;
    wait_valid(tag, v);
    if (v) chk(tag, data_o, exp);
    en_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ff00_exp[0] = 32'h00C00000; ff00_exp[1] = 32'h00800000; ff00_exp[2] = 32'h00400000;
    ff00_exp[3] = 32'h00000000; ff00_exp[4] = 32'hFFC00000; ff00_exp[5] = 32'hFF800000;
`ifdef FUNCT_GEN_SAT_EN
    pos_ovf_exp = 32'h7FFFFFFF;
    neg_ovf_exp = 32'h80000000;
`else
    pos_ovf_exp = 32'h80000000;
    neg_ovf_exp = 32'h70000000;
`endif

    rst = 1'b1; en_i = 1'b0; conf_i = 1'b0; ready_i = 1'b1;
    amp_i = '0; offset_i = '0; freq_i = '0; phase_i = '0; sel_i = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_data", data_o, 32'd0);
    chk("rst_busy", {31'd0, busy_o}, 32'd0);
    rst = 1'b0;

    // Sine at one address per sample; three-edge latency after RUN entry.
    cfg(4'd1, 32'd0, 16'h0100, 16'h0000, 2'd0);
    en_i = 1'b1;
    repeat (3) @(negedge clk);
    chk("lat_pre", {31'd0, valid_o}, 32'd0);
    @(negedge clk);
    chk("lat_first", {31'd0, valid_o}, 32'd1);
    chk("run_busy", {31'd0, busy_o}, 32'd1);
    for (int n = 0; n <= 256; n++) begin
      if (n == 0)   chk("sin_0",   data_o, 32'h00000000);
      if (n == 64)  chk("sin_64",  data_o, 32'h10000000);
      if (n == 128) chk("sin_128", data_o, 32'h00000000);
      if (n == 192) chk("sin_192", data_o, 32'hF0000000);
      if (n == 256) chk("sin_256", data_o, 32'h00000000);
      if (n == 100) chk("sin_valid_100", {31'd0, valid_o}, 32'd1);
      @(negedge clk);
    end
    en_i = 1'b0;
    @(negedge clk);
    chk("flush_valid", {31'd0, valid_o}, 32'd0);
    chk("flush_busy", {31'd0, busy_o}, 32'd0);

    // Asynchronous reset while streaming.
    en_i = 1'b1;
    wait_valid("rerun", ok);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, valid_o}, 32'd0);
    chk("midrst_data", data_o, 32'd0);
    chk("midrst_busy", {31'd0, busy_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    for (int n = 0; n < 3; n++) begin
      chk("post_rst_valid", {31'd0, valid_o}, 32'd1);
      chk("post_rst_data", data_o, 32'd0);
      @(negedge clk);
    end
    en_i = 1'b0;
    repeat (2) @(negedge clk);

    // Half-rate stepping: each triangle address appears twice.
    cfg(4'd1, 32'd0, 16'h0080, 16'h0000, 2'd2);
    en_i = 1'b1;
    wait_valid("tri_half", ok);
    for (int n = 0; n < 10; n++) begin
      chk("tri_half", data_o, 32'(n / 2) << 22);
      @(negedge clk);
    end
    en_i = 1'b0;
    repeat (2) @(negedge clk);

    // Negative step: address 3,2,1,0,255,254.
    cfg(4'd1, 32'd0, 16'hFF00, 16'h0300, 2'd2);
    en_i = 1'b1;
    wait_valid("tri_down", ok);
    for (int n = 0; n < 6; n++) begin
      chk("tri_down", data_o, ff00_exp[n]);
      @(negedge clk);
    end
    en_i = 1'b0;
    repeat (2) @(negedge clk);

    // Backpressure: ready low for 5 cycles mid-stream.
    cfg(4'd1, 32'd0, 16'h0100, 16'h0000, 2'd2);
    en_i = 1'b1;
    ready_i = 1'b1;
    wait_valid("bp", ok);
    k = 0;
    rdy_cnt = 0;
    for (int c = 0; c < 30; c++) begin
      chk("bp_valid", {31'd0, valid_o}, 32'd1);
      chk("bp_data", data_o, 32'(k) << 22);
      ready_i = (c >= 8 && c < 13) ? 1'b0 : 1'b1;
      if (ready_i) rdy_cnt++;
      if (valid_o && ready_i) k++;
      @(negedge clk);
    end
    chk("bp_count", 32'(k), 32'(rdy_cnt));
    ready_i = 1'b1;
    en_i = 1'b0;
    repeat (2) @(negedge clk);

    // Waveform select and amplitude code handling.
    cfg(4'd1, 32'd0, 16'h0000, 16'h0000, 2'd1);
    run_one("cos_0", 32'h10000000);
    cfg(4'd1, 32'd0, 16'h0000, 16'h0000, 2'd3);
    run_one("sq_amp1", 32'h10000000);
    cfg(4'b1000, 32'd0, 16'h0000, 16'h0000, 2'd3);
    run_one("amp_min_rej", 32'h10000000);
    cfg(4'b0000, 32'd0, 16'h0000, 16'h0000, 2'd3);
    run_one("amp_zero_rej", 32'h10000000);
    cfg(4'b1110, 32'd0, 16'h0000, 16'h0000, 2'd3);
    run_one("amp_neg2", 32'hE0000000);

    // Offset overflow in both directions.
    cfg(4'b1110, 32'h90000000, 16'h0000, 16'h0000, 2'd3);
    run_one("ofs_neg_ovf", neg_ovf_exp);
    cfg(4'd1, 32'h70000000, 16'h0000, 16'h0000, 2'd3);
    run_one("ofs_pos_ovf", pos_ovf_exp);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
